// File: rtl/flag_writeback_stage.sv
// Flag writeback stage: resolves the condition field against CPSR,
// commits NZCV and presents a one-entry register-file write.
module flag_writeback_stage #(
    parameter int DATA_WIDTH     = 4,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_cond,
    input  logic [3:0]                in_opcode,
    input  logic                      in_s,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [3:0]                in_nzcv,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_we,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_cond_pass,
    output logic [3:0]                cpsr_nzcv,
    output logic                      cpsr_c
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;

    logic n, z, c, v;
    logic pass;
    logic test_class;
    logic accept;
    logic drain;

    assign {n, z, c, v} = cpsr_nzcv;
    assign cpsr_c       = cpsr_nzcv[1];
    assign out_valid    = (state == FULL);
    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign drain        = out_valid && out_ready;
    assign test_class   = (in_opcode >= 4'b1000) &&
                          (in_opcode <= 4'b1011);

    // Evaluate the condition field against the committed flags
    always_comb begin
        pass = 1'b0;
        unique case (in_cond)
            4'b0000: pass = z;
            4'b0001: pass = !z;
            4'b0010: pass = c;
            4'b0011: pass = !c;
            4'b0100: pass = n;
            4'b0101: pass = !n;
            4'b0110: pass = v;
            4'b0111: pass = !v;
            4'b1000: pass = c && !z;
            4'b1001: pass = !c || z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = !z && (n == v);
            4'b1101: pass = z || (n != v);
            4'b1110: pass = 1'b1;
            4'b1111: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

    // Output register, occupancy state and CPSR commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            out_we        <= 1'b0;
            out_rd        <= '0;
            out_data      <= '0;
            out_cond_pass <= 1'b0;
            cpsr_nzcv     <= 4'b0000;
        end else if (accept) begin
            state         <= FULL;
            out_we        <= pass && !test_class;
            out_rd        <= in_rd;
            out_data      <= in_result;
            out_cond_pass <= pass;
            if (pass && (in_s || test_class)) begin
                cpsr_nzcv <= in_nzcv;
            end
        end else if (drain) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_flag_writeback_stage.sv
// Directed bench for flag_writeback_stage: reset, flag commit,
// condition evaluation, backpressure and carry forwarding.
module tb_flag_writeback_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_cond;
    logic [3:0] in_opcode;
    logic       in_s;
    logic [3:0] in_rd;
    logic [3:0] in_result;
    logic [3:0] in_nzcv;
    logic       out_valid;
    logic       out_ready;
    logic       out_we;
    logic [3:0] out_rd;
    logic [3:0] out_data;
    logic       out_cond_pass;
    logic [3:0] cpsr_nzcv;
    logic       cpsr_c;

    int checks;
    int passed;

    flag_writeback_stage #(
        .DATA_WIDTH    (4),
        .REG_ADDR_WIDTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cond      (in_cond),
        .in_opcode    (in_opcode),
        .in_s         (in_s),
        .in_rd        (in_rd),
        .in_result    (in_result),
        .in_nzcv      (in_nzcv),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_we       (out_we),
        .out_rd       (out_rd),
        .out_data     (out_data),
        .out_cond_pass(out_cond_pass),
        .cpsr_nzcv    (cpsr_nzcv),
        .cpsr_c       (cpsr_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] cond, input logic [3:0] op,
                         input logic s, input logic [3:0] rd,
                         input logic [3:0] res, input logic [3:0] f);
        in_valid  = 1'b1;
        in_cond   = cond;
        in_opcode = op;
        in_s      = s;
        in_rd     = rd;
        in_result = res;
        in_nzcv   = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) $display("FAIL rst0_valid got %b want 0", out_valid); else passed++;
        checks++; if (cpsr_nzcv !== 4'b0000) $display("FAIL rst0_cpsr got %b want 0000", cpsr_nzcv); else passed++;
        checks++; if ({out_we, out_rd, out_data, out_cond_pass} !== 10'd0) $display("FAIL rst0_outs got %b want 0", {out_we, out_rd, out_data, out_cond_pass}); else passed++;
        rst_n = 1'b1;
        step();
        out_ready = 1'b0;
        drive(4'b1110, 4'b0100, 1'b1, 4'd5, 4'h9, 4'b1011);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL rst_fill got %b want 1", out_valid); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_full_ready got %b want 0", in_ready); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_we !== 1'b0) $display("FAIL rst_mid_we got %b want 0", out_we); else passed++;
        checks++; if (cpsr_nzcv !== 4'b0000) $display("FAIL rst_mid_cpsr got %b want 0000", cpsr_nzcv); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", in_ready); else passed++;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_adds();
        drive(4'b1110, 4'b0100, 1'b1, 4'd3, 4'h0, 4'b0110);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL adds_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_we !== 1'b1) $display("FAIL adds_we got %b want 1", out_we); else passed++;
        checks++; if (out_rd !== 4'd3) $display("FAIL adds_rd got %0d want 3", out_rd); else passed++;
        checks++; if (out_data !== 4'h0) $display("FAIL adds_data got %h want 0", out_data); else passed++;
        checks++; if (cpsr_nzcv !== 4'b0110) $display("FAIL adds_cpsr got %b want 0110", cpsr_nzcv); else passed++;
        checks++; if (cpsr_c !== 1'b1) $display("FAIL adds_c got %b want 1", cpsr_c); else passed++;
        step();
        checks++; if (out_valid !== 1'b0) $display("FAIL adds_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_cmp();
        drive(4'b1110, 4'b1010, 1'b0, 4'd7, 4'h2, 4'b1000);
        step();
        in_valid = 1'b0;
        checks++; if (out_we !== 1'b0) $display("FAIL cmp_we got %b want 0", out_we); else passed++;
        checks++; if (out_cond_pass !== 1'b1) $display("FAIL cmp_pass got %b want 1", out_cond_pass); else passed++;
        checks++; if (cpsr_nzcv !== 4'b1000) $display("FAIL cmp_cpsr got %b want 1000", cpsr_nzcv); else passed++;
        step();
    endtask

    task automatic test_cond_fail();
        drive(4'b0000, 4'b1101, 1'b1, 4'd4, 4'h5, 4'b0100);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL eq_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_we !== 1'b0) $display("FAIL eq_we got %b want 0", out_we); else passed++;
        checks++; if (out_cond_pass !== 1'b0) $display("FAIL eq_pass got %b want 0", out_cond_pass); else passed++;
        checks++; if (cpsr_nzcv !== 4'b1000) $display("FAIL eq_cpsr got %b want 1000", cpsr_nzcv); else passed++;
        checks++; if (out_data !== 4'h5) $display("FAIL eq_data got %h want 5", out_data); else passed++;
        step();
        drive(4'b1111, 4'b1101, 1'b1, 4'd6, 4'hA, 4'b0011);
        step();
        in_valid = 1'b0;
        checks++; if (out_cond_pass !== 1'b0) $display("FAIL nv_pass got %b want 0", out_cond_pass); else passed++;
        checks++; if (out_we !== 1'b0) $display("FAIL nv_we got %b want 0", out_we); else passed++;
        checks++; if (cpsr_nzcv !== 4'b1000) $display("FAIL nv_cpsr got %b want 1000", cpsr_nzcv); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(4'b1110, 4'b1101, 1'b0, 4'd1, 4'h7, 4'b0000);
        step();
        drive(4'b1110, 4'b1101, 1'b0, 4'd2, 4'h9, 4'b0000);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready got %b want 0", in_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_data !== 4'h7) $display("FAIL bp_data%0d got %h want 7", i, out_data); else passed++;
            checks++; if (out_rd !== 4'd1) $display("FAIL bp_rd%0d got %0d want 1", i, out_rd); else passed++;
            checks++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL bp_hs%0d got %b want 10", i, {out_valid, in_ready}); else passed++;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== 4'h9) $display("FAIL b2b_data got %h want 9", out_data); else passed++;
        checks++; if (out_rd !== 4'd2) $display("FAIL b2b_rd got %0d want 2", out_rd); else passed++;
        step();
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_carry_chain();
        drive(4'b1110, 4'b0100, 1'b1, 4'd1, 4'h3, 4'b0010);
        step();
        drive(4'b1110, 4'b0101, 1'b0, 4'd2, 4'h4, 4'b0000);
        checks++; if (cpsr_c !== 1'b1) $display("FAIL adc_carry got %b want 1", cpsr_c); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL adc_ready got %b want 1", in_ready); else passed++;
        step();
        checks++; if (out_rd !== 4'd2) $display("FAIL adc_rd got %0d want 2", out_rd); else passed++;
        drive(4'b1110, 4'b1010, 1'b0, 4'd0, 4'h0, 4'b1001);
        step();
        drive(4'b1010, 4'b1101, 1'b0, 4'd8, 4'hC, 4'b0000);
        checks++; if (cpsr_nzcv !== 4'b1001) $display("FAIL ge_setup got %b want 1001", cpsr_nzcv); else passed++;
        step();
        checks++; if ({out_cond_pass, out_we} !== 2'b11) $display("FAIL ge_pass got %b want 11", {out_cond_pass, out_we}); else passed++;
        drive(4'b1011, 4'b1101, 1'b0, 4'd9, 4'hD, 4'b0000);
        step();
        in_valid = 1'b0;
        checks++; if ({out_cond_pass, out_we} !== 2'b00) $display("FAIL lt_pass got %b want 00", {out_cond_pass, out_we}); else passed++;
        checks++; if (cpsr_nzcv !== 4'b1001) $display("FAIL lt_cpsr got %b want 1001", cpsr_nzcv); else passed++;
        step();
        checks++; if (out_valid !== 1'b0) $display("FAIL end_drain got %b want 0", out_valid); else passed++;
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_cond   = 4'b0;
        in_opcode = 4'b0;
        in_s      = 1'b0;
        in_rd     = 4'd0;
        in_result = 4'h0;
        in_nzcv   = 4'b0;
        #1;
        test_reset();
        test_adds();
        test_cmp();
        test_cond_fail();
        test_back_to_back();
        test_carry_chain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
